// File: rtl/rob_pkg.sv
// -----------------------------------------------------------------------------
// rob_pkg
// Shared definitions for the read-ordering blocks: AXI R response codes and
// the state encoding of the R ordering FSM.
// No ports (package).
// -----------------------------------------------------------------------------
package rob_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOOKUP = 2'd1,
      ST_SEND   = 2'd2
   } r_ord_state_e;

endpackage : rob_pkg

// File: rtl/r_if.sv
// -----------------------------------------------------------------------------
// r_if
// AXI-style R channel bundle (valid/ready handshake plus id/data/resp/last).
// Modports:
//   sender   - drives valid, id, data, resp, last; samples ready
//   receiver - samples valid, id, data, resp, last; drives ready
// -----------------------------------------------------------------------------
interface r_if #(
   parameter int ID_WIDTH   = 32,
   parameter int DATA_WIDTH = 64,
   parameter int RESP_WIDTH = 2
);

   logic                  valid;
   logic                  ready;
   logic [ID_WIDTH-1:0]   id;
   logic [DATA_WIDTH-1:0] data;
   logic [RESP_WIDTH-1:0] resp;
   logic                  last;

   modport sender (
      output valid, id, data, resp, last,
      input  ready
   );

   modport receiver (
      input  valid, id, data, resp, last,
      output ready
   );

endinterface : r_if

// File: rtl/r_beat_checker.sv
// -----------------------------------------------------------------------------
// r_beat_checker
// Counts delivered beats of the burst currently described by the UID cache and
// flags a beat whose LAST flag disagrees with the burst length from the
// tag-map (LAST early, or no LAST on the final beat).
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   fill_i        cache fill: restart count, capture fill_len_i
//   fill_len_i    burst length (beats-1) of the newly cached burst
//   beat_done_i   a beat was handed to the master this cycle
//   beat_last_i   LAST flag of the beat currently being presented
//   mismatch_o    combinational: presented beat violates the burst length
// -----------------------------------------------------------------------------
module r_beat_checker #(
   parameter int LEN_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 fill_i,
   input  logic [LEN_WIDTH-1:0] fill_len_i,
   input  logic                 beat_done_i,
   input  logic                 beat_last_i,
   output logic                 mismatch_o
);

   // One extra bit so an overrunning burst never wraps back onto len.
   localparam logic [LEN_WIDTH:0] CNT_ONE = {{LEN_WIDTH{1'b0}}, 1'b1};

   logic [LEN_WIDTH:0]   cnt_q;
   logic [LEN_WIDTH:0]   cnt_d;
   logic [LEN_WIDTH-1:0] len_q;
   logic [LEN_WIDTH-1:0] len_d;
   logic                 at_len;

   // Beat counter and captured length: restart on fill, advance per delivery.
   always_comb begin
      cnt_d = cnt_q;
      len_d = len_q;
      if (fill_i) begin
         cnt_d = '0;
         len_d = fill_len_i;
      end else if (beat_done_i) begin
         cnt_d = cnt_q + CNT_ONE;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Counter state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         len_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         len_q <= len_d;
      end
   end

   assign at_len     = (cnt_q == {1'b0, len_q});
   // Count is the 0-based index of the beat on the output right now.
   assign mismatch_o = (beat_last_i & ~at_len) | (~beat_last_i & at_len);

endmodule : r_beat_checker

// File: rtl/r_ordering_unit.sv
// -----------------------------------------------------------------------------
// r_ordering_unit
// Return path of the AR ordering stage. R beats arrive tagged with an internal
// UID; the UID is translated back to the master's original ID through the
// tag-map (with a one-entry cache so only the first beat of a burst needs a
// lookup), the beat is forwarded with the original ID, and the UID is released
// to the tag-map after the last beat of the burst has been delivered.
//
// Optional feature (macro R_ORD_LEN_CHECK_EN): beat count vs. burst length
// checking; a mismatching beat is returned with SLVERR and len_err pulses.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   r_in            R beats from slave side (id = UID), receiver modport
//   r_out           R beats to master (id = original ID), sender modport
//   lookup_req/uid  tag-map lookup request, held until lookup_gnt
//   lookup_gnt      lookup result valid (lookup_orig_id, lookup_len)
//   free_req/uid    one-cycle UID release after a delivered last beat
//   len_err         one-cycle pulse: burst length mismatch (check build only)
// -----------------------------------------------------------------------------
module r_ordering_unit
   import rob_pkg::*;
#(
   parameter int ID_WIDTH   = 32,
   parameter int DATA_WIDTH = 64,
   parameter int RESP_WIDTH = 2,
   parameter int LEN_WIDTH  = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   r_if.receiver                r_in,
   r_if.sender                  r_out,
   output logic                 lookup_req,
   output logic [ID_WIDTH-1:0]  lookup_uid,
   input  logic                 lookup_gnt,
   input  logic [ID_WIDTH-1:0]  lookup_orig_id,
   input  logic [LEN_WIDTH-1:0] lookup_len,
   output logic                 free_req,
   output logic [ID_WIDTH-1:0]  free_uid,
   output logic                 len_err
);

   r_ord_state_e          state_q,      state_d;
   logic [ID_WIDTH-1:0]   uid_q,        uid_d;
   logic [DATA_WIDTH-1:0] data_q,       data_d;
   logic [RESP_WIDTH-1:0] resp_q,       resp_d;
   logic                  last_q,       last_d;
   logic [ID_WIDTH-1:0]   out_id_q,     out_id_d;
   logic                  cache_vld_q,  cache_vld_d;
   logic [ID_WIDTH-1:0]   cache_uid_q,  cache_uid_d;
   logic [ID_WIDTH-1:0]   cache_orig_q, cache_orig_d;
   logic                  free_req_q,   free_req_d;
   logic [ID_WIDTH-1:0]   free_uid_q,   free_uid_d;
   logic                  len_err_q,    len_err_d;

   logic st_idle;
   logic st_lookup;
   logic st_send;
   logic hs_in;
   logic hs_out;
   logic cache_hit;
   logic fill;
   logic beat_err;

   assign st_idle   = (state_q == ST_IDLE);
   assign st_lookup = (state_q == ST_LOOKUP);
   assign st_send   = (state_q == ST_SEND);
   assign hs_in     = r_in.valid & st_idle;
   assign hs_out    = st_send & r_out.ready;
   assign cache_hit = cache_vld_q & (r_in.id == cache_uid_q);
   assign fill      = st_lookup & lookup_gnt;

`ifdef R_ORD_LEN_CHECK_EN
   logic len_mismatch;

   r_beat_checker #(
      .LEN_WIDTH (LEN_WIDTH)
   ) u_beat_checker (
      .clk         (clk),
      .rst         (rst),
      .fill_i      (fill),
      .fill_len_i  (lookup_len),
      .beat_done_i (hs_out),
      .beat_last_i (last_q),
      .mismatch_o  (len_mismatch)
   );

   // Only a beat actually on the output can be in error.
   assign beat_err = st_send & len_mismatch;
`else
   logic unused_len;

   assign unused_len = ^lookup_len;
   assign beat_err   = 1'b0;
`endif

   // Next-state logic: beat capture, UID translation, cache and release.
   always_comb begin
      state_d      = state_q;
      uid_d        = uid_q;
      data_d       = data_q;
      resp_d       = resp_q;
      last_d       = last_q;
      out_id_d     = out_id_q;
      cache_vld_d  = cache_vld_q;
      cache_uid_d  = cache_uid_q;
      cache_orig_d = cache_orig_q;
      free_req_d   = 1'b0;
      free_uid_d   = free_uid_q;
      len_err_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (hs_in) begin
               uid_d  = r_in.id;
               data_d = r_in.data;
               resp_d = r_in.resp;
               last_d = r_in.last;
               if (cache_hit) begin
                  out_id_d = cache_orig_q;
                  state_d  = ST_SEND;
               end else begin
                  state_d  = ST_LOOKUP;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_LOOKUP: begin
            if (lookup_gnt) begin
               // A different UID simply replaces the cached burst.
               out_id_d     = lookup_orig_id;
               cache_vld_d  = 1'b1;
               cache_uid_d  = uid_q;
               cache_orig_d = lookup_orig_id;
               state_d      = ST_SEND;
            end else begin
               state_d = ST_LOOKUP;
            end
         end

         ST_SEND: begin
            if (hs_out) begin
               state_d   = ST_IDLE;
               len_err_d = beat_err;
               if (last_q) begin
                  // Burst complete: forget it and hand the UID back.
                  cache_vld_d = 1'b0;
                  free_req_d  = 1'b1;
                  free_uid_d  = uid_q;
               end else begin
                  cache_vld_d = cache_vld_q;
               end
            end else begin
               state_d = ST_SEND;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and payload registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         uid_q        <= '0;
         data_q       <= '0;
         resp_q       <= '0;
         last_q       <= 1'b0;
         out_id_q     <= '0;
         cache_vld_q  <= 1'b0;
         cache_uid_q  <= '0;
         cache_orig_q <= '0;
         free_req_q   <= 1'b0;
         free_uid_q   <= '0;
         len_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         uid_q        <= uid_d;
         data_q       <= data_d;
         resp_q       <= resp_d;
         last_q       <= last_d;
         out_id_q     <= out_id_d;
         cache_vld_q  <= cache_vld_d;
         cache_uid_q  <= cache_uid_d;
         cache_orig_q <= cache_orig_d;
         free_req_q   <= free_req_d;
         free_uid_q   <= free_uid_d;
         len_err_q    <= len_err_d;
      end
   end

   assign r_in.ready  = st_idle;

   assign r_out.valid = st_send;
   assign r_out.id    = out_id_q;
   assign r_out.data  = data_q;
   assign r_out.resp  = beat_err ? RESP_SLVERR : resp_q;
   assign r_out.last  = last_q;

   assign lookup_req  = st_lookup;
   assign lookup_uid  = uid_q;

   assign free_req    = free_req_q;
   assign free_uid    = free_uid_q;
   assign len_err     = len_err_q;

endmodule : r_ordering_unit
